load_unit: RTL

- Read-side companion to the data RAM's store path; sits between the core's memory stage and the word-organised data RAM.
- Accepts a load request (LB/LH/LW/LBU/LHU), issues word reads to the synchronous-read RAM and extracts the addressed byte/halfword/word.
- Sign- or zero-extends the result and returns it over a valid/ready response handshake.
- Multi-cycle FSM; one load outstanding at a time.

---
 rtl/load_unit_pkg.sv | 21 ++
 rtl/load_align.sv | 29 ++
 rtl/load_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/load_unit_pkg.sv
// Load funct3 encodings and the decode helpers shared by load_unit and load_align.
package load_unit_pkg;

  localparam logic [2:0] LOAD_B  = 3'b000;
  localparam logic [2:0] LOAD_H  = 3'b001;
  localparam logic [2:0] LOAD_W  = 3'b010;
  localparam logic [2:0] LOAD_BU = 3'b100;
  localparam logic [2:0] LOAD_HU = 3'b101;

  function automatic logic is_legal(input logic [2:0] f3);
    return (f3 == LOAD_B) || (f3 == LOAD_H) || (f3 == LOAD_W) ||
           (f3 == LOAD_BU) || (f3 == LOAD_HU);
  endfunction

  // True when the access spills past the first word and needs a second read.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == LOAD_H) || (f3 == LOAD_HU)) && (off == 2'd3)) ||
           ((f3 == LOAD_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select plus sign/zero extension for loads; zero latency, no handshake.
// W1 only contributes for accesses that spill past W0.
module load_align
  import load_unit_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] sh;

  always_comb begin
    // Little-endian: shifting the {W1,W0} pair right by the byte offset puts the addressed lane at bit 0.
    sh   = 32'({w1, w0} >> {off, 3'b000});
    data = '0;
    case (funct3)
      LOAD_B:  data = {{24{sh[7]}}, sh[7:0]};
      LOAD_H:  data = {{16{sh[15]}}, sh[15:0]};
      LOAD_W:  data = sh;
      LOAD_BU: data = {24'd0, sh[7:0]};
      LOAD_HU: data = {16'd0, sh[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load FSM in front of a sync-read word RAM; 3 cycles accept-to-rsp_valid (5 split), result held until rsp_ready.
// LOAD_SPLIT_EN enables two-read misaligned loads; otherwise misaligned loads return rsp_err.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int WORD_AW = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_funct3,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic               mem_re,
  output logic [WORD_AW-1:0] mem_addr,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    CAP0 = 3'd2,
    RD1  = 3'd3,
    CAP1 = 3'd4,
    RESP = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               mem_re_q, mem_re_d;
  logic [WORD_AW-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         off_q, off_d;
  logic               reject;
  logic [31:0]        align_w0;
  logic [31:0]        align_data;

`ifdef LOAD_SPLIT_EN
  logic [31:0] w0_q, w0_d;
  assign align_w0 = (state_q == CAP1) ? w0_q : mem_rdata;
  assign reject   = !is_legal(req_funct3);
`else
  assign align_w0 = mem_rdata;
  assign reject   = !is_legal(req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
`endif

  load_align u_align (
    .w0     (align_w0),
    .w1     (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (align_data)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    f3_d        = f3_q;
    off_d       = off_q;
`ifdef LOAD_SPLIT_EN
    w0_d        = w0_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d        = req_funct3;
          off_d       = req_addr[1:0];
          req_ready_d = 1'b0;
          if (reject) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d    = RD0;
            mem_re_d   = 1'b1;
            mem_addr_d = req_addr[ADDR_W-1:2];
          end
        end
      end
      RD0: state_d = CAP0;
      CAP0: begin
`ifdef LOAD_SPLIT_EN
        if (is_misaligned(f3_q, off_q)) begin
          state_d    = RD1;
          w0_d       = mem_rdata;
          mem_re_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end else
`endif
        begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = align_data;
        end
      end
`ifdef LOAD_SPLIT_EN
      RD1: state_d = CAP1;
      CAP1: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = align_data;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      f3_q        <= '0;
      off_q       <= '0;
`ifdef LOAD_SPLIT_EN
      w0_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
`ifdef LOAD_SPLIT_EN
      w0_q        <= w0_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;

endmodule
